packet_tx_framer: RTL and testbench

PACKET_TX_FRAMER -- requirements
Module: packet_tx_framer

---
 rtl/packet_tx_framer_if.sv | 23 ++
 rtl/packet_tx_framer.sv | 86 ++++++++
 tb/tb_packet_tx_framer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/packet_tx_framer_if.sv
// packet_tx_framer_if: packet request fields and byte-stream outputs of the TX framer
interface packet_tx_framer_if;
    logic         start;
    logic         pkt_type;
    logic [7:0]   pkt_metadata;
    logic [63:0]  pkt_prefix;
    logic [255:0] pkt_data;
    logic         RX_valid;
    logic [7:0]   data_SPI_to_FIB;
    logic         byte_valid;
    logic         busy;
    logic         done;

    modport master (
        output start, pkt_type, pkt_metadata, pkt_prefix, pkt_data,
        input  RX_valid, data_SPI_to_FIB, byte_valid, busy, done
    );

    modport slave (
        input  start, pkt_type, pkt_metadata, pkt_prefix, pkt_data,
        output RX_valid, data_SPI_to_FIB, byte_valid, busy, done
    );
endinterface

// File: rtl/packet_tx_framer.sv
// packet_tx_framer: serialises an interest (9 B) or data (41 B) packet MSB-first after a one-cycle strobe; PKT_TX_CHECKSUM_EN appends an XOR byte
module packet_tx_framer (
    input  logic                clk,
    input  logic                rst,
    packet_tx_framer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, STROBE, SEND, DONE} state_t;

    state_t       state_q, state_d;
    logic [327:0] pkt_q, pkt_d;
    logic         type_q, type_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [5:0]   n_last;
    logic [7:0]   tx_byte;

`ifdef PKT_TX_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    assign n_last  = type_q ? 6'd41 : 6'd9;
    assign tx_byte = (cnt_q == n_last) ? csum_q : pkt_q[327:320];

    // running XOR of the bytes already sent, cleared when a packet is captured
    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && bus.start) csum_d = 8'h00;
        else if (state_q == SEND) csum_d = csum_q ^ pkt_q[327:320];
    end

    // checksum accumulator register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) csum_q <= 8'h00;
        else csum_q <= csum_d;
    end
`else
    assign n_last  = type_q ? 6'd40 : 6'd8;
    assign tx_byte = pkt_q[327:320];
`endif

    // next-state: capture in IDLE, strobe once, shift one byte per cycle until the last index
    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.start) begin
                pkt_d   = bus.pkt_type ? {bus.pkt_metadata, bus.pkt_prefix, bus.pkt_data}
                                       : {bus.pkt_metadata, bus.pkt_prefix, 256'd0};
                type_d  = bus.pkt_type;
                cnt_d   = 6'd0;
                state_d = STROBE;
            end
            STROBE: state_d = SEND;
            SEND: begin
                pkt_d = {pkt_q[319:0], 8'h00};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == n_last) begin
                    cnt_d   = 6'd0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state, packet shift register, type and byte counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pkt_q   <= '0;
            type_q  <= 1'b0;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.RX_valid        = state_q == STROBE;
    assign bus.byte_valid      = state_q == SEND;
    assign bus.busy            = state_q == STROBE || state_q == SEND;
    assign bus.done            = state_q == DONE;
    assign bus.data_SPI_to_FIB = bus.byte_valid ? tx_byte : 8'h00;
endmodule

// File: tb/tb_packet_tx_framer.sv
// tb_packet_tx_framer: random and directed frames checked against a byte-list reference model
module tb_packet_tx_framer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] exp_q[$];

    packet_tx_framer_if bus ();

    packet_tx_framer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {RX_valid, byte_valid, busy, done, data}
    function automatic logic [11:0] outs();
        return {bus.RX_valid, bus.byte_valid, bus.busy, bus.done, bus.data_SPI_to_FIB};
    endfunction

    // reference: the packet as a list of bytes in wire order
    task automatic build(input logic t, input logic [7:0] m, input logic [63:0] p, input logic [255:0] d);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(m);
        for (int i = 7; i >= 0; i--) exp_q.push_back(p[i*8 +: 8]);
        if (t) for (int i = 31; i >= 0; i--) exp_q.push_back(d[i*8 +: 8]);
`ifdef PKT_TX_CHECKSUM_EN
        x = 8'h00;
        foreach (exp_q[i]) x ^= exp_q[i];
        exp_q.push_back(x);
`endif
    endtask

    task automatic garble();
        bus.pkt_type     = 1'($urandom);
        bus.pkt_metadata = 8'($urandom);
        bus.pkt_prefix   = {$urandom, $urandom};
        for (int j = 0; j < 8; j++) bus.pkt_data[j*32 +: 32] = $urandom;
    endtask

    // drive a request in IDLE and return just after the capture edge
    task automatic start_frame(input logic t, input logic [7:0] m, input logic [63:0] p, input logic [255:0] d);
        @(negedge clk);
        bus.pkt_type     = t;
        bus.pkt_metadata = m;
        bus.pkt_prefix   = p;
        bus.pkt_data     = d;
        bus.start        = 1'b1;
        build(t, m, p, d);
        @(posedge clk);
    endtask

    // check the strobe, every byte and the done cycle following a capture edge
    task automatic observe(input bit hold, input bit disturb);
        @(negedge clk);
        check("strobe", 32'(outs()), {20'd0, 4'b1010, 8'h00});
        if (!hold) bus.start = 1'b0;
        if (disturb) garble();
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("byte%0d", i), 32'(outs()), {20'd0, 4'b0110, exp_q[i]});
            if (disturb) begin
                garble();
                if (i == 2) bus.start = 1'b1;
                if (i == 3) bus.start = 1'b0;
            end
        end
        @(negedge clk);
        check("done", 32'(outs()), {20'd0, 4'b0001, 8'h00});
    endtask

    initial begin
        logic [255:0] d;
        logic [63:0]  p;
        logic [7:0]   m;
        logic         t;
        bus.start = 1'b0;
        garble();
        #3;
        check("reset_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_outs", 32'(outs()), 32'd0);

        start_frame(1'b0, 8'd112, 64'h0000FFFF0000FFFF, '0);
        observe(1'b0, 1'b0);

        for (int i = 0; i < 32; i++) d[i*8 +: 8] = 8'(i);
        start_frame(1'b1, 8'hA5, 64'h0123456789ABCDEF, d);
        observe(1'b0, 1'b1);
        @(negedge clk);
        check("after_done", 32'(outs()), 32'd0);

        for (int n = 0; n < 16; n++) begin
            t = 1'($urandom);
            m = 8'($urandom);
            p = {$urandom, $urandom};
            for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
            start_frame(t, m, p, d);
            observe(1'b0, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        start_frame(1'b0, 8'h3C, 64'hDEADBEEF00112233, '0);
        observe(1'b1, 1'b0);
        @(negedge clk);
        check("b2b_idle", 32'(outs()), 32'd0);
        @(posedge clk);
        observe(1'b0, 1'b0);

        start_frame(1'b0, 8'd112, 64'h0000FFFF0000FFFF, '0);
        @(negedge clk);
        check("rst_strobe", 32'(outs()), {20'd0, 4'b1010, 8'h00});
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_pre_byte", 32'(outs()), {20'd0, 4'b0110, exp_q[i]});
        end
        #2 rst = 1'b0;
        #1 check("async_rst", 32'(outs()), 32'd0);
        @(negedge clk);
        check("rst_hold", 32'(outs()), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_release", 32'(outs()), 32'd0);
        start_frame(1'b0, 8'd112, 64'h0000FFFF0000FFFF, '0);
        observe(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
